// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared constants, state encoding and the enabled-oscillator
//               search used by the tdc readout sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

  localparam int NUM_RO  = 8;
  localparam int NUM_SEG = 8;
  localparam int SEG_W   = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_SEND   = 3'd5;
  localparam logic [2:0] ST_NEXT   = 3'd6;
  localparam logic [2:0] ST_FIN    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLEAR  = ST_CLEAR,
    S_GAP    = ST_GAP,
    S_HOLD   = ST_HOLD,
    S_SETTLE = ST_SETTLE,
    S_SEND   = ST_SEND,
    S_NEXT   = ST_NEXT,
    S_FIN    = ST_FIN
  } state_e;

  // Lowest set bit of mask at index >= from. Bit 3 of the result set means
  // no such oscillator exists; bits 2:0 hold the index otherwise.
  function automatic logic [3:0] find_next_ro(input logic [NUM_RO-1:0] mask,
                                              input logic [3:0]        from);
    logic [3:0] r;
    r = 4'b1000;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b0, i[2:0]};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tdc_delay_cnt
// Description : Loadable 8-bit down-counter. A wait of N cycles is made by
//               loading N-1; expire_o is high on the final cycle of the wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_delay_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] cnt_o,
  output logic       expire_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Load takes priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != 8'd0)  cnt_d = cnt_q - 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign expire_o = (cnt_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/tdc_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tdc_readout_ctrl
// Description : Sequences clear/arm/hold of each enabled ring oscillator in
//               the tdc, then streams the 8 snapshot segment bytes of each.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_readout_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned ACT_CYCLES    = 16,
  parameter logic [7:0]  RO_MASK       = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SEG_W-1:0] tdc_data,
  output logic             ro_activate,
  output logic             ro_deactivate,
  output logic [2:0]       out_sel,
  output logic [2:0]       bit_sel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SEG_W-1:0] m_data,
  output logic [2:0]       m_ro_idx,
  output logic [2:0]       m_seg_idx,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  // The last GAP cycle already carries ro_activate, so HOLD covers the rest.
  // With ACT_CYCLES==1 HOLD is a single cycle with ro_activate low.
  localparam logic [7:0] C_GAP_LOAD    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] C_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] C_HOLD_LOAD   = (ACT_CYCLES > 1) ? 8'(ACT_CYCLES - 2) : 8'd0;

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        GAP_CYCLES < 1    || GAP_CYCLES > 255    ||
        ACT_CYCLES < 1    || ACT_CYCLES > 255) begin : g_bad_param
      $error("tdc_readout_ctrl: wait parameters must lie in 1..255");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [2:0]       out_sel_q, out_sel_d;
  logic [2:0]       bit_sel_q, bit_sel_d;
  logic             m_valid_q, m_valid_d;
  logic [SEG_W-1:0] m_data_q, m_data_d;
  logic [2:0]       m_ro_idx_q, m_ro_idx_d;
  logic [2:0]       m_seg_idx_q, m_seg_idx_d;
  logic             m_last_q, m_last_d;
  logic             ro_act_q, ro_act_d;
  logic             ro_deact_q, ro_deact_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic [7:0]       cnt_val;
  logic [7:0]       w_cnt;
  logic             w_expire;
  logic [3:0]       w_first;
  logic [3:0]       w_nxt;
  logic             w_gap_last_next;

  tdc_delay_cnt u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .cnt_o      (w_cnt),
    .expire_o   (w_expire)
  );

  assign w_first = find_next_ro(RO_MASK, 4'd0);
  assign w_nxt   = find_next_ro(RO_MASK, {1'b0, out_sel_q} + 4'd1);

  // Next GAP cycle is the final one: either entering GAP with a 1-cycle gap,
  // or the counter is one step away from expiring.
  assign w_gap_last_next = (state_q == S_CLEAR) ? (GAP_CYCLES == 1) : (w_cnt == 8'd1);

  // Next-state and next-output decode; abort overrides any active state.
  always_comb begin
    state_d     = state_q;
    out_sel_d   = out_sel_q;
    bit_sel_d   = bit_sel_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_ro_idx_d  = m_ro_idx_q;
    m_seg_idx_d = m_seg_idx_q;
    m_last_d    = m_last_q;
    cnt_load    = 1'b0;
    cnt_val     = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!w_first[3]) begin
            out_sel_d = w_first[2:0];
            bit_sel_d = 3'd0;
            state_d   = S_CLEAR;
          end else begin
            state_d   = S_FIN;
          end
        end
      end
      S_CLEAR: begin
        state_d  = S_GAP;
        cnt_load = 1'b1;
        cnt_val  = C_GAP_LOAD;
      end
      S_GAP: begin
        if (w_expire) begin
          state_d  = S_HOLD;
          cnt_load = 1'b1;
          cnt_val  = C_HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (w_expire) begin
          state_d  = S_SETTLE;
          cnt_load = 1'b1;
          cnt_val  = C_SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (w_expire) begin
          state_d     = S_SEND;
          m_valid_d   = 1'b1;
          m_data_d    = tdc_data;
          m_ro_idx_d  = out_sel_q;
          m_seg_idx_d = bit_sel_q;
          m_last_d    = (bit_sel_q == 3'(NUM_SEG - 1)) && w_nxt[3];
        end
      end
      S_SEND: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (bit_sel_q != 3'(NUM_SEG - 1)) begin
            bit_sel_d = bit_sel_q + 3'd1;
            state_d   = S_SETTLE;
            cnt_load  = 1'b1;
            cnt_val   = C_SETTLE_LOAD;
          end else begin
            state_d   = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (!w_nxt[3]) begin
          out_sel_d = w_nxt[2:0];
          bit_sel_d = 3'd0;
          state_d   = S_CLEAR;
        end else begin
          state_d   = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE) && (state_q != S_FIN)) begin
      state_d   = S_FIN;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    ro_act_d   = ((state_d == S_GAP) && w_gap_last_next) ||
                 ((state_d == S_HOLD) && (ACT_CYCLES > 1));
    // The FIN pulses are registered decodes of the FIN state itself.
    ro_deact_d = (state_d == S_CLEAR) || (state_q == S_FIN);
    done_d     = (state_q == S_FIN);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_sel_q   <= 3'd0;
      bit_sel_q   <= 3'd0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ro_idx_q  <= 3'd0;
      m_seg_idx_q <= 3'd0;
      m_last_q    <= 1'b0;
      ro_act_q    <= 1'b0;
      ro_deact_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_sel_q   <= out_sel_d;
      bit_sel_q   <= bit_sel_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_ro_idx_q  <= m_ro_idx_d;
      m_seg_idx_q <= m_seg_idx_d;
      m_last_q    <= m_last_d;
      ro_act_q    <= ro_act_d;
      ro_deact_q  <= ro_deact_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ro_activate   = ro_act_q;
  assign ro_deactivate = ro_deact_q;
  assign out_sel       = out_sel_q;
  assign bit_sel       = bit_sel_q;
  assign m_valid       = m_valid_q;
  assign m_data        = m_data_q;
  assign m_ro_idx      = m_ro_idx_q;
  assign m_seg_idx     = m_seg_idx_q;
  assign m_last        = m_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
`default_nettype wire
